// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Multicycle RV32I control sequencer with memory handshake and retire counter
// Walks each instruction through fetch/decode/execute/memory/writeback and drives datapath selects.
module multicycle_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic                 RegWrite,
  output logic [1:0]           ALUOp,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  logic [3:0]           state_q;
  logic [3:0]           state_d;
  logic                 illegal_q;
  logic [INSTRET_W-1:0] instret_q;
  logic                 retire;

  logic                 mem_req_c;
  logic                 pc_write_c;
  logic                 ir_write_c;
  logic                 mem_write_c;
  logic                 reg_write_c;

  // Next-state sequencing; op is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d = S_TRAP;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_TRAP;
    endcase
  end

  always_comb begin
    mem_req_c   = 1'b0;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pc_write_c = mem_ready;
        ir_write_c = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        // The write strobe is held for the whole stall, not just the ready cycle.
        mem_req_c   = 1'b1;
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        pc_write_c = Zero;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_c = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  assign retire = !reset &&
                  ((state_q == S_MEMWB) ||
                   (state_q == S_ALUWB) ||
                   (state_q == S_BEQ) ||
                   ((state_q == S_MEMWRITE) && mem_ready));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) begin
        illegal_q <= 1'b1;
      end
      if (retire) begin
        instret_q <= instret_q + INSTRET_ONE;
      end
    end
  end

  // Architectural side effects are suppressed while reset is held, whatever state we were in.
  assign mem_req  = mem_req_c   & ~reset;
  assign PCWrite  = pc_write_c  & ~reset;
  assign IRWrite  = ir_write_c  & ~reset;
  assign MemWrite = mem_write_c & ~reset;
  assign RegWrite = reg_write_c & ~reset;

  assign illegal = illegal_q;
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - Scoreboard bench for multicycle_ctrl against an instruction-level model
module tb_multicycle_ctrl;

  localparam int W = 4;

  typedef struct packed {
    logic [3:0]   st;
    logic         req;
    logic         pcw;
    logic         adr;
    logic         mw;
    logic         irw;
    logic [1:0]   rs;
    logic [1:0]   sa;
    logic [1:0]   sb;
    logic [1:0]   imm;
    logic         rw;
    logic [1:0]   aop;
    logic         ill;
    logic [W-1:0] ir;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [6:0]   op;
  logic         Zero;
  logic         mem_ready;
  logic         mem_req;
  logic         PCWrite;
  logic         AdrSrc;
  logic         MemWrite;
  logic         IRWrite;
  logic [1:0]   ResultSrc;
  logic [1:0]   ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [1:0]   ImmSrc;
  logic         RegWrite;
  logic [1:0]   ALUOp;
  logic         illegal;
  logic [3:0]   state;
  logic [W-1:0] instret;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [W-1:0] cnt = '0;
  vec_t exp_q[$];
  int   cyc_q[$];

  multicycle_ctrl #(.INSTRET_W(W)) dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUOp(ALUOp), .illegal(illegal),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  // Control word each state is defined to present, from the datapath's point of view.
  function automatic vec_t model(input logic [3:0] s, input logic rdy, input logic z,
                                 input logic rst, input logic [6:0] o, input logic [W-1:0] c);
    vec_t v;
    v = '0;
    v.st  = s;
    v.ir  = c;
    v.ill = (s == 4'd11);
    case (s)
      4'd0:  begin v.req = 1; v.sb = 2'b10; v.rs = 2'b10; v.pcw = rdy; v.irw = rdy; end
      4'd1:  begin v.sa = 2'b01; v.sb = 2'b01; end
      4'd2:  begin v.sa = 2'b10; v.sb = 2'b01; end
      4'd3:  begin v.req = 1; v.adr = 1; end
      4'd4:  begin v.rs = 2'b01; v.rw = 1; end
      4'd5:  begin v.req = 1; v.adr = 1; v.mw = 1; end
      4'd6:  begin v.sa = 2'b10; v.aop = 2'b10; end
      4'd7:  begin v.sa = 2'b10; v.sb = 2'b01; v.aop = 2'b10; end
      4'd8:  begin v.rw = 1; end
      4'd9:  begin v.sa = 2'b10; v.aop = 2'b01; v.pcw = z; end
      4'd10: begin v.sa = 2'b01; v.sb = 2'b10; v.pcw = 1; end
      default: ;
    endcase
    if (o == 7'b0100011) v.imm = 2'b01;
    else if (o == 7'b1100011) v.imm = 2'b10;
    else if (o == 7'b1101111) v.imm = 2'b11;
    if (rst) begin
      v.req = 0; v.pcw = 0; v.mw = 0; v.irw = 0; v.rw = 0;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    vec_t e;
    vec_t a;
    int   c;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = cyc_q.pop_front();
      a = {state, mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ImmSrc, RegWrite, ALUOp, illegal, instret};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctrl cycle %0d: got %h expected %h (state %0d vs %0d, instret %0d vs %0d)",
                 c, a, e, a.st, e.st, a.ir, e.ir);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs, record what this cycle must look like, then advance the counter model.
  task automatic step(input logic [3:0] s, input logic rdy, input logic z,
                      input logic rst, input logic ret);
    mem_ready = rdy;
    Zero      = z;
    reset     = rst;
    exp_q.push_back(model(s, rdy, z, rst, op, cnt));
    cyc_q.push_back(cycle);
    @(posedge clk);
    #1;
    cycle++;
    if (rst) cnt = '0;
    else if (ret) cnt = cnt + 1'b1;
  endtask

  function automatic logic [6:0] kind_op(input int kind, input logic [6:0] iop);
    case (kind)
      0: return 7'b0110011;
      1: return 7'b0010011;
      2: return 7'b0000011;
      3: return 7'b0100011;
      4: return 7'b1100011;
      5: return 7'b1101111;
      default: return iop;
    endcase
  endfunction

  // kind: 0 R, 1 I, 2 lw, 3 sw, 4 beq, 5 jal, 6 illegal. abort = phase index to reset in, -1 none.
  task automatic run_instr(input int kind, input int fst, input int mst, input logic z,
                           input int abort, input int hold, input logic [6:0] iop);
    int ph[$];
    int stalls;
    logic [3:0] s;
    op = kind_op(kind, iop);
    case (kind)
      0: ph = '{0, 1, 6, 8};
      1: ph = '{0, 1, 7, 8};
      2: ph = '{0, 1, 2, 3, 4};
      3: ph = '{0, 1, 2, 5};
      4: ph = '{0, 1, 9};
      5: ph = '{0, 1, 10, 8};
      default: ph = '{0, 1, 11};
    endcase
    for (int i = 0; i < ph.size(); i++) begin
      s = 4'(ph[i]);
      stalls = (s == 4'd0) ? fst : ((s == 4'd3 || s == 4'd5) ? mst : 0);
      for (int j = 0; j < stalls; j++) step(s, 1'b0, z, 1'b0, 1'b0);
      if (i == abort) begin
        step(s, 1'b0, z, 1'b1, 1'b0);
        return;
      end
      if (stalls > 0 || s == 4'd0 || s == 4'd3 || s == 4'd5)
        step(s, 1'b1, z, 1'b0, (i == ph.size() - 1) && kind != 6);
      else
        step(s, 1'($urandom), z, 1'b0, (i == ph.size() - 1) && kind != 6);
    end
    if (kind == 6) begin
      for (int j = 0; j < hold; j++) step(4'd11, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      step(4'd11, 1'($urandom), z, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int kind;
    int abort;
    logic [6:0] iop;
    reset = 1'b1; op = '0; Zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    run_instr(0, 0, 0, 1'b0, -1, 0, 7'b0);
    run_instr(2, 0, 2, 1'b0, -1, 0, 7'b0);
    run_instr(3, 0, 1, 1'b0, -1, 0, 7'b0);
    run_instr(4, 0, 0, 1'b1, -1, 0, 7'b0);
    run_instr(4, 0, 0, 1'b0, -1, 0, 7'b0);
    run_instr(5, 0, 0, 1'b0, -1, 0, 7'b0);
    chk("instret_before_trap", 32'(instret), 32'd6);
    run_instr(6, 0, 0, 1'b0, -1, 20, 7'b0000000);
    chk("state_after_trap_reset", 32'(state), 32'd0);
    chk("illegal_after_reset", 32'(illegal), 32'd0);
    chk("instret_after_reset", 32'(instret), 32'd0);
    run_instr(2, 1, 1, 1'b0, 3, 0, 7'b0);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_instret", 32'(instret), 32'd0);
    for (int i = 0; i < 17; i++) run_instr(0, 0, 0, 1'b0, -1, 0, 7'b0);
    chk("instret_wrap", 32'(instret), 32'd1);

    for (int n = 0; n < 200; n++) begin
      kind  = ($urandom_range(0, 19) == 0) ? 6 : int'($urandom_range(0, 5));
      abort = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      case ($urandom_range(0, 3))
        0: iop = 7'b0000000;
        1: iop = 7'b1111111;
        2: iop = 7'b0110111;
        default: iop = 7'b1100111;
      endcase
      run_instr(kind, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom),
                abort, $urandom_range(1, 20), iop);
    end

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
